// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the responder FSM state type.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MEM  = 2'd1,
      RD_RESP = 2'd2,
      WR_RESP = 2'd3
   } bram_state_e;

endpackage

// File: rtl/bram_sp.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables,
// one-cycle read latency, no reset (coded for block-RAM inference).
module bram_sp #(
   parameter int unsigned DEPTH      = 32768,
   parameter int unsigned ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [3:0]            we,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   // byte-enabled write and registered read of the addressed word
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < 4; b++) begin
         if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/axi_bram_slave.sv
// AXI4-Lite responder serving single-beat reads/writes from a block RAM.
// One transaction in flight; write wins when AW+W and AR arrive together.
// Optional macro AXI_BRAM_RANGE_CHECK_EN: byte addresses >= DEPTH*4 get
// SLVERR, read zero and do not write; otherwise addresses alias modulo DEPTH.
module axi_bram_slave #(
   parameter int unsigned DEPTH      = 32768,
   parameter int unsigned ADDR_WIDTH = 15
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] s_axi_araddr,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   input  logic [31:0] s_axi_awaddr,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready
);
   import axi_lite_pkg::*;

   bram_state_e           state_q, state_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rd_err_q, rd_err_d;

   logic                  idle;
   logic                  wr_pair;
   logic                  wr_go;
   logic                  rd_go;
   logic                  aw_oor;
   logic                  ar_oor;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [3:0]            ram_we;
   logic [31:0]           ram_rdata;
   logic                  unused_addr_bits;

`ifdef AXI_BRAM_RANGE_CHECK_EN
   localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;
   assign aw_oor = ({1'b0, s_axi_awaddr} >= BYTE_LIMIT);
   assign ar_oor = ({1'b0, s_axi_araddr} >= BYTE_LIMIT);
`else
   assign aw_oor = 1'b0;
   assign ar_oor = 1'b0;
`endif

   // byte-offset bits (and, without range check, upper bits) are don't-care
   assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

   // readies gated by rstn so nothing is accepted while reset is held
   assign idle          = (state_q == IDLE) && rstn;
   assign wr_pair       = s_axi_awvalid && s_axi_wvalid;
   assign wr_go         = idle && wr_pair;
   assign rd_go         = idle && !wr_pair && s_axi_arvalid;
   assign s_axi_awready = wr_go;
   assign s_axi_wready  = wr_go;
   assign s_axi_arready = idle && !wr_pair;

   // single RAM port: write address on a write accept, else the read address
   assign ram_addr = wr_pair ? s_axi_awaddr[ADDR_WIDTH+1:2] : s_axi_araddr[ADDR_WIDTH+1:2];
   assign ram_we   = (wr_go && !aw_oor) ? s_axi_wstrb : '0;

   bram_sp #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (s_axi_wdata),
      .rdata (ram_rdata)
   );

   // next-state and response-register logic
   always_comb begin
      state_d  = state_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      bresp_d  = bresp_q;
      rd_err_d = rd_err_q;
      unique case (state_q)
         IDLE: begin
            if (wr_go) begin
               bresp_d = aw_oor ? RESP_SLVERR : RESP_OKAY;
               state_d = WR_RESP;
            end else if (rd_go) begin
               rd_err_d = ar_oor;
               state_d  = RD_MEM;
            end
         end
         RD_MEM: begin
            rdata_d = rd_err_q ? '0 : ram_rdata;
            rresp_d = rd_err_q ? RESP_SLVERR : RESP_OKAY;
            state_d = RD_RESP;
         end
         RD_RESP: if (s_axi_rready) state_d = IDLE;
         WR_RESP: if (s_axi_bready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and response registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
         bresp_q  <= RESP_OKAY;
         rd_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
         bresp_q  <= bresp_d;
         rd_err_q <= rd_err_d;
      end
   end

   assign s_axi_rvalid = (state_q == RD_RESP);
   assign s_axi_bvalid = (state_q == WR_RESP);
   assign s_axi_rdata  = rdata_q;
   assign s_axi_rresp  = rresp_q;
   assign s_axi_bresp  = bresp_q;

endmodule

// File: tb/tb_axi_bram_slave.sv
// Self-checking bench for axi_bram_slave: directed scenarios then random
// reads/writes against a word-array reference model.
module tb_axi_bram_slave;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned AW    = 10;

   logic        clk;
   logic        rstn;
   logic [31:0] s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic [31:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [31:0] ref_mem   [DEPTH];
   logic [3:0]  ref_known [DEPTH];

   axi_bram_slave #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_oor(input logic [31:0] a);
`ifdef AXI_BRAM_RANGE_CHECK_EN
      return {1'b0, a} >= 33'(DEPTH * 4);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int unsigned widx(input logic [31:0] a);
      return (a / 4) % DEPTH;
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] a);
      return is_oor(a) ? 2'b10 : 2'b00;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int unsigned i;
      if (!is_oor(a)) begin
         i = widx(a);
         for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
               ref_mem[i][8*b +: 8] = d[8*b +: 8];
               ref_known[i][b]      = 1'b1;
            end
         end
      end
   endtask

   task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [31:0] m);
      int unsigned i;
      if (is_oor(a)) begin
         d = 32'h0;
         m = 32'hFFFF_FFFF;
      end else begin
         i = widx(a);
         d = ref_mem[i];
         for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{ref_known[i][b]}};
      end
   endtask

   // ---------------- bus tasks (entered shortly after a rising edge) ----------------
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int unsigned n;
      n = 0;
      s_axi_awaddr  = a;
      s_axi_wdata   = d;
      s_axi_wstrb   = s;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      s_axi_bready  = 1'b1;
      #1;
      while (!(s_axi_awready && s_axi_wready) && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk1("wr_accept_in_time", n < 20, 1'b1);
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      model_write(a, d, s);
      chk1("wr_bvalid_n_plus_1", s_axi_bvalid, 1'b1);
      chk32("wr_bresp", 32'(s_axi_bresp), 32'(exp_resp(a)));
      chk1("wr_awready_busy", s_axi_awready, 1'b0);
      @(posedge clk); #1;
      chk1("wr_bvalid_drop", s_axi_bvalid, 1'b0);
   endtask

   task automatic axi_read(input logic [31:0] a);
      int unsigned n;
      logic [31:0] d, m;
      n = 0;
      s_axi_araddr  = a;
      s_axi_arvalid = 1'b1;
      s_axi_rready  = 1'b1;
      #1;
      while (!s_axi_arready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk1("rd_accept_in_time", n < 20, 1'b1);
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      chk1("rd_rvalid_not_early", s_axi_rvalid, 1'b0);
      @(posedge clk); #1;
      model_read(a, d, m);
      chk1("rd_rvalid_n_plus_2", s_axi_rvalid, 1'b1);
      chk32("rd_rresp", 32'(s_axi_rresp), 32'(exp_resp(a)));
      chk32("rd_rdata", s_axi_rdata & m, d & m);
      @(posedge clk); #1;
      chk1("rd_rvalid_drop", s_axi_rvalid, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d, m, a, held;
      for (int i = 0; i < int'(DEPTH); i++) ref_known[i] = 4'h0;

      rstn          = 1'b0;
      s_axi_araddr  = 32'h0;
      s_axi_arvalid = 1'b1;
      s_axi_rready  = 1'b0;
      s_axi_awaddr  = 32'h0;
      s_axi_awvalid = 1'b1;
      s_axi_wdata   = 32'h0;
      s_axi_wstrb   = 4'h0;
      s_axi_wvalid  = 1'b1;
      s_axi_bready  = 1'b0;

      // reset state, with every request valid held high
      #3;
      chk1("rst_arready", s_axi_arready, 1'b0);
      chk1("rst_awready", s_axi_awready, 1'b0);
      chk1("rst_wready", s_axi_wready, 1'b0);
      chk1("rst_rvalid", s_axi_rvalid, 1'b0);
      chk1("rst_bvalid", s_axi_bvalid, 1'b0);
      chk32("rst_rdata", s_axi_rdata, 32'h0);
      chk32("rst_rresp", 32'(s_axi_rresp), 32'h0);
      chk32("rst_bresp", 32'(s_axi_bresp), 32'h0);
      s_axi_arvalid = 1'b0;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;

      // full write then readback
      axi_write(32'h10, 32'hDEAD_BEEF, 4'hF);
      axi_read(32'h10);
      // partial strobed write over existing data
      axi_write(32'h10, 32'h1122_3344, 4'b0101);
      model_read(32'h10, d, m);
      chk32("partial_model_value", d, 32'hDE22_BE44);
      axi_read(32'h10);
      // zero strobe: response, no change
      axi_write(32'h13, 32'hFFFF_FFFF, 4'h0);
      axi_read(32'h10);

      // lone AW for 5 cycles, then W joins
      s_axi_awaddr  = 32'h20;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk1("lone_aw_awready", s_axi_awready, 1'b0);
         chk1("lone_aw_wready", s_axi_wready, 1'b0);
         @(posedge clk); #1;
      end
      chk1("lone_aw_no_bvalid", s_axi_bvalid, 1'b0);
      axi_write(32'h20, 32'hA5A5_5A5A, 4'hF);
      chk1("lone_aw_single_resp", s_axi_bvalid, 1'b0);
      axi_read(32'h20);

      // simultaneous AR + AW + W: write first, read right after B handshake
      s_axi_araddr  = 32'h30;
      s_axi_arvalid = 1'b1;
      s_axi_rready  = 1'b1;
      s_axi_awaddr  = 32'h30;
      s_axi_wdata   = 32'h0BAD_F00D;
      s_axi_wstrb   = 4'hF;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      s_axi_bready  = 1'b1;
      #1;
      chk1("prio_arready_low", s_axi_arready, 1'b0);
      chk1("prio_awready_high", s_axi_awready, 1'b1);
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      model_write(32'h30, 32'h0BAD_F00D, 4'hF);
      chk1("prio_bvalid", s_axi_bvalid, 1'b1);
      chk1("prio_arready_busy", s_axi_arready, 1'b0);
      @(posedge clk); #1;
      chk1("prio_bvalid_drop", s_axi_bvalid, 1'b0);
      chk1("prio_arready_after_b", s_axi_arready, 1'b1);
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      chk1("prio_rd_not_early", s_axi_rvalid, 1'b0);
      @(posedge clk); #1;
      chk1("prio_rvalid", s_axi_rvalid, 1'b1);
      chk32("prio_rdata_new", s_axi_rdata, 32'h0BAD_F00D);
      @(posedge clk); #1;

      // read stall with rready low, then reset mid-stall
      s_axi_araddr  = 32'h10;
      s_axi_arvalid = 1'b1;
      s_axi_rready  = 1'b0;
      #1;
      chk1("stall_arready", s_axi_arready, 1'b1);
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      @(posedge clk); #1;
      model_read(32'h10, held, m);
      for (int k = 0; k < 10; k++) begin
         chk1("stall_rvalid_held", s_axi_rvalid, 1'b1);
         chk32("stall_rdata_held", s_axi_rdata, held);
         chk1("stall_arready_low", s_axi_arready, 1'b0);
         @(posedge clk); #1;
      end
      #2 rstn = 1'b0;
      #1;
      chk1("midrst_rvalid", s_axi_rvalid, 1'b0);
      chk32("midrst_rdata", s_axi_rdata, 32'h0);
      chk1("midrst_arready", s_axi_arready, 1'b0);
      #1 rstn = 1'b1;
      #1;
      chk1("postrst_idle", s_axi_arready, 1'b1);
      @(posedge clk); #1;
      axi_read(32'h10);

      // range: write word 0, then write at DEPTH*4
      axi_write(32'h0, 32'hDEAD_BEEF, 4'hF);
      axi_write(32'(DEPTH * 4), 32'hCAFE_F00D, 4'hF);
      axi_read(32'h0);
      model_read(32'h0, d, m);
`ifdef AXI_BRAM_RANGE_CHECK_EN
      chk32("range_model_word0", d, 32'hDEAD_BEEF);
`else
      chk32("alias_model_word0", d, 32'hCAFE_F00D);
`endif
      axi_read(32'(DEPTH * 4));

      // random mix over a small word set with aliasing/out-of-range offsets
      for (int k = 0; k < 200; k++) begin
         a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3))
           + 32'($urandom_range(0, 2) * DEPTH * 4);
         if ($urandom_range(0, 9) == 0) a = $urandom;
         if ($urandom_range(0, 1) == 1)
            axi_write(a, $urandom, 4'($urandom_range(0, 15)));
         else
            axi_read(a);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
